// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with valid/ready load and gap-free back-to-back frames.
// Optional even-parity bit appended after the data when PISO_PARITY_EN is defined.
module piso_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned         CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0]    LAST  = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e                 state_q;
    logic [FRAME_LEN-1:0]   sreg_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sout_q;
    logic                   sout_valid_q;
    logic                   done_q;

    logic [FRAME_LEN-1:0]   frame;
    logic                   last;
    logic                   accept;

    // Bit that leaves the register next, and the register after it leaves.
    function automatic logic head(input logic [FRAME_LEN-1:0] v);
        return LSB_FIRST ? v[0] : v[FRAME_LEN-1];
    endfunction

    function automatic logic [FRAME_LEN-1:0] shift(input logic [FRAME_LEN-1:0] v);
        return LSB_FIRST ? {1'b0, v[FRAME_LEN-1:1]} : {v[FRAME_LEN-2:0], 1'b0};
    endfunction

    // Parity sits at the far end of the register so it is transmitted last.
    always_comb begin
`ifdef PISO_PARITY_EN
        frame = LSB_FIRST ? {^din, din} : {din, ^din};
`else
        frame = din;
`endif
    end

    assign last       = (state_q == SHIFT) && (cnt_q == LAST);
    assign load_ready = (state_q == IDLE) || last;
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else if (accept) begin
            state_q      <= SHIFT;
            sreg_q       <= shift(frame);
            cnt_q        <= '0;
            sout_q       <= head(frame);
            sout_valid_q <= 1'b1;
            done_q       <= 1'b0;
        end else if (state_q == SHIFT) begin
            if (last) begin
                state_q      <= IDLE;
                sout_q       <= 1'b0;
                sout_valid_q <= 1'b0;
                done_q       <= 1'b0;
            end else begin
                sreg_q       <= shift(sreg_q);
                cnt_q        <= cnt_q + 1'b1;
                sout_q       <= head(sreg_q);
                done_q       <= (cnt_q == LAST - 1'b1);
            end
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = sout_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: MSB-first and LSB-first instances share stimulus,
// expected bit streams are queued per lane and checked by a negedge monitor.
module tb_piso_tx;

    localparam int unsigned W = 4;
`ifdef PISO_PARITY_EN
    localparam int unsigned FL = W + 1;
`else
    localparam int unsigned FL = W;
`endif

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [W-1:0] din;
    logic         load_valid;
    logic         ready_w [2];
    logic         sout_w  [2];
    logic         sv_w    [2];
    logic         busy_w  [2];
    logic         done_w  [2];

    exp_t q [2][$];
    int   total;
    int   bad;
    bit   started;

    piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
        .load_ready(ready_w[0]), .sout(sout_w[0]), .sout_valid(sv_w[0]),
        .busy(busy_w[0]), .done(done_w[0])
    );

    piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
        .load_ready(ready_w[1]), .sout(sout_w[1]), .sout_valid(sv_w[1]),
        .busy(busy_w[1]), .done(done_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected frame: data bits in transmit order, then even parity if enabled.
    function automatic void push_frame(input logic [W-1:0] d);
        for (int k = 0; k < int'(FL); k++) begin
            logic bm;
            logic bl;
            if (k < int'(W)) begin
                bm = d[W-1-k];
                bl = d[k];
            end else begin
                bm = ^d;
                bl = ^d;
            end
            q[0].push_back('{b: bm, last: (k == int'(FL) - 1)});
            q[1].push_back('{b: bl, last: (k == int'(FL) - 1)});
        end
    endfunction

    // One clock cycle of stimulus; ready is predicted from the pending bit count.
    task automatic step(input bit v, input logic [W-1:0] d, input bit r);
        bit mr;
        bit acc;
        mr  = (q[0].size() <= 1);
        acc = v && mr && !r;
        reset      = r;
        load_valid = v;
        din        = d;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (ready_w[i] !== mr) begin
                bad++;
                $display("FAIL load_ready lane%0d t=%0t got=%b want=%b", i, $time, ready_w[i], mr);
            end
        end
        @(posedge clk);
        if (r) begin
            q[0].delete();
            q[1].delete();
        end else if (acc) begin
            push_frame(d);
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (busy_w[i] !== sv_w[i]) begin
                    bad++;
                    $display("FAIL busy lane%0d t=%0t got=%b want=%b", i, $time, busy_w[i], sv_w[i]);
                end else if (sv_w[i] === 1'b1) begin
                    if (q[i].size() == 0) begin
                        bad++;
                        $display("FAIL extra_bit lane%0d t=%0t got sout=%b want no valid bit", i, $time, sout_w[i]);
                    end else begin
                        exp_t e;
                        e = q[i].pop_front();
                        if (sout_w[i] !== e.b || done_w[i] !== e.last) begin
                            bad++;
                            $display("FAIL bit lane%0d t=%0t got sout=%b done=%b want sout=%b done=%b",
                                     i, $time, sout_w[i], done_w[i], e.b, e.last);
                        end
                    end
                end else if (sv_w[i] !== 1'b0 || sout_w[i] !== 1'b0 || done_w[i] !== 1'b0
                             || q[i].size() != 0) begin
                    bad++;
                    $display("FAIL idle lane%0d t=%0t got sv=%b sout=%b done=%b pending=%0d want 0 0 0 0",
                             i, $time, sv_w[i], sout_w[i], done_w[i], q[i].size());
                end
            end
        end
    end

    initial begin
        total      = 0;
        bad        = 0;
        started    = 1'b0;
        reset      = 1'b1;
        load_valid = 1'b0;
        din        = '0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        started = 1'b1;

        // Single frame, then idle.
        step(1'b1, 4'b1011, 1'b0);
        repeat (FL + 2) step(1'b0, 4'b0000, 1'b0);

        // Back-to-back: second word offered while the first is on its last bit.
        step(1'b1, 4'b1011, 1'b0);
        repeat (FL - 1) step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0110, 1'b0);
        repeat (FL + 2) step(1'b0, 4'b0000, 1'b0);

        // Word offered mid-frame must be ignored.
        step(1'b1, 4'b1011, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        repeat (FL + 1) step(1'b0, 4'b0000, 1'b0);

        // Reset aborts a frame; a fresh word right after goes out intact.
        step(1'b1, 4'b1100, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b1, 4'b1011, 1'b0);
        repeat (FL + 2) step(1'b0, 4'b0000, 1'b0);

        // LSB-first pattern and parity-0 word.
        step(1'b1, 4'b0001, 1'b0);
        repeat (FL + 1) step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0110, 1'b0);
        repeat (FL + 1) step(1'b0, 4'b0000, 1'b0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 49) == 0));
        end
        repeat (FL + 2) step(1'b0, 4'b0000, 1'b0);

        for (int i = 0; i < 2; i++) begin
            total++;
            if (q[i].size() != 0) begin
                bad++;
                $display("FAIL drain lane%0d pending=%0d want 0", i, q[i].size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
